// File: rtl/crypto_round_engine.sv
// Iterative 8-bit key-XOR/rotate round engine with valid/ready byte handshakes.
// One round per clock; decrypt runs the encrypt rounds backwards with a pre-rotated key.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a byte
//   ROUND | one key-XOR + rotate round per cycle
//   DONE  | result presented, waiting for out_ready
module crypto_round_engine #(
  parameter int NUM_ROUNDS = 4,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] in_key,
  input  logic       in_mode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int                DEC_ROT  = (NUM_ROUNDS - 1) % 8;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_ROUNDS - 1);

  state_t           state_q, state_d;
  logic [7:0]       st_q, st_d;
  logic [7:0]       rk_q, rk_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic [15:0]      key_dbl;
  logic [7:0]       key_dec;

  function automatic logic [7:0] rotr1(input logic [7:0] x);
    return {x[0], x[7:1]};
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  // Decrypt starts from the last encrypt round key: in_key rotated left NUM_ROUNDS-1 times.
  always_comb begin
    key_dbl = {in_key, in_key} << DEC_ROT;
    key_dec = key_dbl[15:8];
  end

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    rk_d        = rk_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_data;
          rk_d    = in_mode ? key_dec : in_key;
          mode_d  = in_mode;
          cnt_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (mode_q) begin
          st_d = rotl1(st_q) ^ rk_q;
          rk_d = rotr1(rk_q);
        end else begin
          st_d = rotr1(st_q ^ rk_q);
          rk_d = rotl1(rk_q);
        end
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // First DONE cycle captures the result; the handshake is only honoured once it is shown.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = st_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      st_q        <= '0;
      rk_q        <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      rk_q        <= rk_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == ROUND);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_crypto_round_engine.sv
// Directed and round-trip bench for crypto_round_engine (NUM_ROUNDS=4).
module tb_crypto_round_engine;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] in_key;
  logic       in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  crypto_round_engine #(.NUM_ROUNDS(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_enc(input logic [7:0] d, input logic [7:0] k);
    logic [7:0] s, r, x;
    s = d;
    r = k;
    for (int i = 0; i < 4; i++) begin
      x = s ^ r;
      s = {x[0], x[7:1]};
      r = {r[6:0], r[7]};
    end
    return s;
  endfunction

  // Called #1 after a rising edge with the engine in IDLE; returns #1 after the accept edge.
  task automatic send(input logic [7:0] d, input logic [7:0] k, input logic m);
    in_data  = d;
    in_key   = k;
    in_mode  = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic get_result(output logic [7:0] r, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 50);
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    r = out_data;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  logic [7:0] res, d, k, c;
  int         lat;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_key    = 8'h00;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: latency and basic encrypt
    send(8'h01, 8'h00, 1'b0);
    chk("t1_busy", busy, 1);
    chk("t1_in_ready_round", in_ready, 0);
    get_result(res, lat);
    chk("t1_data", res, 8'h10);
    chk("t1_latency", lat, 5);
    chk("t1_idle_ready", in_ready, 1);
    chk("t1_valid_drop", out_valid, 0);
    chk("t1_hold_data", out_data, 8'h10);

    // Test 2: known vector both directions
    send(8'h00, 8'h01, 1'b0);
    get_result(res, lat);
    chk("t2_enc", res, 8'h55);
    send(8'h55, 8'h01, 1'b1);
    get_result(res, lat);
    chk("t2_dec", res, 8'h00);
    chk("t2_dec_latency", lat, 5);

    // Test 3: all-ones key
    send(8'h00, 8'hFF, 1'b0);
    get_result(res, lat);
    chk("t3_enc_ff", res, 8'h00);

    // Test 4: stall in DONE, in_valid ignored
    send(8'h00, 8'h01, 1'b0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 50);
    chk("t4_reach_done", out_valid, 1);
    in_data  = 8'h33;
    in_key   = 8'h77;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("t4_stall_valid", out_valid, 1);
      chk("t4_stall_data", out_data, 8'h55);
      chk("t4_stall_in_ready", in_ready, 0);
      chk("t4_stall_busy", busy, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("t4_release_valid", out_valid, 0);
    chk("t4_release_ready", in_ready, 1);
    chk("t4_release_data", out_data, 8'h55);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_nothing_queued_busy", busy, 0);
    chk("t4_nothing_queued_valid", out_valid, 0);

    // Test 5: input changes during ROUND are ignored; out_ready early has no effect
    send(8'h00, 8'h01, 1'b0);
    in_key    = 8'hFF;
    in_mode   = 1'b1;
    in_data   = 8'hAA;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("t5_early_ready_busy", busy, 1);
    get_result(res, lat);
    chk("t5_enc", res, 8'h55);

    // Test 6: asynchronous reset in the middle of ROUND
    send(8'h00, 8'hFF, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_in_ready", in_ready, 1);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_out_data", out_data, 8'h00);
    chk("t6_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_no_partial", out_valid, 0);
    send(8'h00, 8'h01, 1'b0);
    get_result(res, lat);
    chk("t6_after_rst_enc", res, 8'h55);

    // Random round trips
    for (int i = 0; i < 200; i++) begin
      d = 8'($urandom);
      k = 8'($urandom);
      send(d, k, 1'b0);
      get_result(c, lat);
      chk("rt_enc", c, model_enc(d, k));
      send(c, k, 1'b1);
      get_result(res, lat);
      chk("rt_dec", res, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
